// File: rtl/rdcost_pkg.sv
// Shared types, constants and helpers for the rate-distortion cost calculator.
// RDCOST_SAT_EN selects a saturating cost output instead of a wrapping one.
package rdcost_pkg;

    localparam int unsigned NUM_LANES    = 4;
    localparam int unsigned RES_W        = 9;
    localparam int unsigned LAMBDA_SHIFT = 6;
    localparam int unsigned COST_W       = 21;
    localparam int unsigned MIN_LOG2     = 4;
    localparam int unsigned MAX_LOG2     = 12;

    localparam int unsigned LOG2_LANES = $clog2(NUM_LANES);
    localparam int unsigned CNT_W      = MAX_LOG2 - LOG2_LANES + 1;
    localparam int unsigned BEAT_W     = RES_W + LOG2_LANES;
    localparam int unsigned ACC_W      = COST_W;
    localparam int unsigned PROD_W     = 28;

    // The wrapping build only ever observes the low COST_W bits of the sum.
`ifdef RDCOST_SAT_EN
    localparam int unsigned SUM_W = 23;
`else
    localparam int unsigned SUM_W = COST_W;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        MULT,
        ADD,
        DONE
    } state_t;

    function automatic logic [3:0] clamp_log2(input logic [3:0] log2_in);
        if (log2_in < 4'(MIN_LOG2)) return 4'(MIN_LOG2);
        if (log2_in > 4'(MAX_LOG2)) return 4'(MAX_LOG2);
        return log2_in;
    endfunction

endpackage

// File: rtl/rdcost_calc_abs_sum_tree.sv
// Per-lane saturating absolute value of signed residuals, summed into one
// beat total.
module abs_sum_tree
    import rdcost_pkg::*;
(
    input  logic [NUM_LANES*RES_W-1:0] res_data,
    output logic [BEAT_W-1:0]          beat_sum
);

    localparam int unsigned MAG_W = RES_W - 1;

    // Only the most negative residual overflows MAG_W bits; clip it to all-ones.
    function automatic logic [MAG_W-1:0] abs_sat(input logic [RES_W-1:0] r);
        logic [RES_W-1:0] m;
        m = r[RES_W-1] ? -r : r;
        return m[RES_W-1] ? '1 : m[MAG_W-1:0];
    endfunction

    always_comb begin
        beat_sum = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            beat_sum = beat_sum + BEAT_W'(abs_sat(res_data[i*RES_W +: RES_W]));
        end
    end

endmodule

// File: rtl/rdcost_calc.sv
// Rate-distortion cost: SAD of the residual stream plus (lambda*rate) >> LAMBDA_SHIFT.
// RDCOST_SAT_EN saturates the cost at all-ones; otherwise it wraps.
module rdcost_calc
    import rdcost_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3:0]                 blk_size_log2,
    input  logic [15:0]                lambda,
    input  logic [11:0]                rate_bits,
    input  logic                       res_valid,
    output logic                       res_ready,
    input  logic [NUM_LANES*RES_W-1:0] res_data,
    output logic [COST_W-1:0]          rdcost,
    output logic                       rdcost_done,
    output logic                       busy
);

    state_t              state_q, state_d;
    logic [15:0]         lambda_q, lambda_d;
    logic [11:0]         rate_q, rate_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [BEAT_W-1:0]   beat_sum;
    logic [3:0]          size_log2;

    abs_sum_tree u_abs_sum_tree (
        .res_data (res_data),
        .beat_sum (beat_sum)
    );

    always_comb begin
        state_d   = state_q;
        lambda_d  = lambda_q;
        rate_d    = rate_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        sum_d     = sum_q;
        size_log2 = clamp_log2(blk_size_log2);

        // start overrides every state, including a beat arriving in the same cycle.
        if (start) begin
            state_d  = ACCUM;
            lambda_d = lambda;
            rate_d   = rate_bits;
            acc_d    = '0;
            cnt_d    = CNT_W'(1) << (size_log2 - 4'(LOG2_LANES));
            prod_d   = '0;
            sum_d    = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (res_valid) begin
                        acc_d = acc_q + ACC_W'(beat_sum);
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) state_d = MULT;
                    end
                end
                MULT: begin
                    prod_d  = PROD_W'(lambda_q) * PROD_W'(rate_q);
                    state_d = ADD;
                end
                ADD: begin
                    sum_d   = SUM_W'(acc_q) + SUM_W'(prod_q >> LAMBDA_SHIFT);
                    state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lambda_q <= '0;
            rate_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            lambda_q <= lambda_d;
            rate_q   <= rate_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            sum_q    <= sum_d;
        end
    end

    // sum_q is cleared on start and only loaded entering DONE, so rdcost holds
    // the last result until the next candidate begins.
`ifdef RDCOST_SAT_EN
    assign rdcost = (|sum_q[SUM_W-1:COST_W]) ? '1 : sum_q[COST_W-1:0];
`else
    assign rdcost = sum_q;
`endif

    assign res_ready   = (state_q == ACCUM);
    assign busy        = (state_q == ACCUM) || (state_q == MULT) || (state_q == ADD);
    assign rdcost_done = (state_q == DONE);

endmodule

// File: tb/tb_rdcost_calc.sv
// Randomized self-checking bench for rdcost_calc against a cost model built
// from plain arithmetic over the applied residuals.
module tb_rdcost_calc;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  blk_size_log2;
    logic [15:0] lambda;
    logic [11:0] rate_bits;
    logic        res_valid;
    logic        res_ready;
    logic [35:0] res_data;
    logic [20:0] rdcost;
    logic        rdcost_done;
    logic        busy;

    int          nvec;
    int          nerr;
    int          done_cnt;
    longint      exp_acc;
    logic [15:0] cur_lam;
    logic [11:0] cur_rb;
    int          cur_beats;

    rdcost_calc dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .blk_size_log2 (blk_size_log2),
        .lambda        (lambda),
        .rate_bits     (rate_bits),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .rdcost        (rdcost),
        .rdcost_done   (rdcost_done),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rdcost_done === 1'b1) done_cnt++;
    end

    initial begin
        #900us;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint lane_abs(input logic [8:0] r);
        longint v;
        v = longint'($signed(r));
        if (v < 0) v = -v;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic logic [20:0] model_cost();
        longint s;
        s = exp_acc + ((longint'(cur_lam) * longint'(cur_rb)) / 64);
`ifdef RDCOST_SAT_EN
        if (s > 64'sd2097151) s = 2097151;
`else
        s = s % 2097152;
`endif
        return 21'(s);
    endfunction

    function automatic logic [35:0] rand_word();
        return {4'($urandom), $urandom};
    endfunction

    task automatic do_start(input logic [3:0] l2, input logic [15:0] lam, input logic [11:0] rb);
        int l;
        start = 1'b1;
        blk_size_log2 = l2;
        lambda = lam;
        rate_bits = rb;
        tick();
        start = 1'b0;
        res_valid = 1'b0;
        blk_size_log2 = 4'($urandom);
        lambda = 16'($urandom);
        rate_bits = 12'($urandom);
        l = (l2 < 4) ? 4 : (l2 > 12) ? 12 : int'(l2);
        cur_beats = (1 << l) / 4;
        cur_lam = lam;
        cur_rb = rb;
        exp_acc = 0;
        nvec++;
        if (busy !== 1'b1 || res_ready !== 1'b1 || rdcost !== 21'd0 || rdcost_done !== 1'b0) begin
            nerr++;
            $display("FAIL start_state busy=%b ready=%b rdcost=%0d done=%b, required 1 1 0 0",
                     busy, res_ready, rdcost, rdcost_done);
        end
    endtask

    task automatic feed_beats(input int n, input int gap_mode, input bit use_fixed, input logic [35:0] word);
        int got;
        int step;
        bit v;
        got = 0;
        step = 0;
        while (got < n) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (step % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            res_valid = v;
            res_data = use_fixed ? word : rand_word();
            nvec++;
            if (res_ready !== 1'b1 || rdcost_done !== 1'b0 || busy !== 1'b1) begin
                nerr++;
                $display("FAIL accum_state beat=%0d ready=%b done=%b busy=%b, required 1 0 1",
                         got, res_ready, rdcost_done, busy);
            end
            if (v) begin
                for (int i = 0; i < 4; i++) exp_acc += lane_abs(res_data[i*9 +: 9]);
                got++;
            end
            tick();
            step++;
        end
        res_valid = 1'b0;
    endtask

    // Called right after the edge that accepted the last beat.
    task automatic finish_check();
        int seen;
        int d0;
        logic [20:0] exp_cost;
        seen = -1;
        d0 = done_cnt;
        exp_cost = model_cost();
        res_valid = 1'b1;
        res_data = rand_word();
        for (int k = 0; k < 6; k++) begin
            if (rdcost_done === 1'b1 && seen < 0) begin
                seen = k;
                nvec++;
                if (rdcost !== exp_cost) begin
                    nerr++;
                    $display("FAIL cost got=%0d required=%0d", rdcost, exp_cost);
                end
                nvec++;
                if (busy !== 1'b0) begin
                    nerr++;
                    $display("FAIL busy_in_done got=%b required=0", busy);
                end
            end else if (seen < 0) begin
                nvec++;
                if (res_ready !== 1'b0 || busy !== 1'b1) begin
                    nerr++;
                    $display("FAIL tail_state k=%0d ready=%b busy=%b, required 0 1", k, res_ready, busy);
                end
            end
            tick();
        end
        res_valid = 1'b0;
        nvec++;
        if (seen != 2) begin
            nerr++;
            $display("FAIL done_latency got=%0d required=2 (-1 means no done)", seen);
        end
        nvec++;
        if (done_cnt - d0 != 1) begin
            nerr++;
            $display("FAIL done_pulses got=%0d required=1", done_cnt - d0);
        end
        nvec++;
        if (rdcost !== exp_cost || busy !== 1'b0 || res_ready !== 1'b0) begin
            nerr++;
            $display("FAIL idle_hold rdcost=%0d busy=%b ready=%b, required %0d 0 0",
                     rdcost, busy, res_ready, exp_cost);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        blk_size_log2 = '0;
        lambda = '0;
        rate_bits = '0;
        res_valid = 1'b0;
        res_data = '0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (rdcost !== 21'd0 || rdcost_done !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b0) begin
                nerr++;
                $display("FAIL reset_state rdcost=%0d done=%b busy=%b ready=%b, required 0 0 0 0",
                         rdcost, rdcost_done, busy, res_ready);
            end
            res_valid = 1'b1;
            tick();
        end
        res_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_start(4'd4, 16'd64, 12'd10);
        feed_beats(cur_beats, 0, 1'b1, {9'h1FD, 9'h003, 9'h1FD, 9'h003});
        finish_check();
        nvec++;
        if (rdcost !== 21'd58) begin
            nerr++;
            $display("FAIL basic_const got=%0d required=58", rdcost);
        end
    endtask

    task automatic test_stall();
        do_start(4'd4, 16'd64, 12'd10);
        feed_beats(cur_beats, 1, 1'b1, {9'h1FD, 9'h003, 9'h1FD, 9'h003});
        finish_check();
        nvec++;
        if (rdcost !== 21'd58) begin
            nerr++;
            $display("FAIL stall_const got=%0d required=58", rdcost);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            do_start(4'($urandom_range(0, 15)), 16'($urandom), 12'($urandom));
            feed_beats(cur_beats, 2, 1'b0, '0);
            finish_check();
        end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        // abort mid-block: the new start coincides with a valid beat
        do_start(4'd5, 16'($urandom), 12'($urandom));
        feed_beats(1, 0, 1'b0, '0);
        res_valid = 1'b1;
        res_data = rand_word();
        do_start(4'd4, 16'($urandom), 12'($urandom));
        // start coincident with the final beat
        feed_beats(cur_beats - 1, 0, 1'b0, '0);
        res_valid = 1'b1;
        res_data = rand_word();
        do_start(4'd2, 16'($urandom), 12'($urandom));
        feed_beats(cur_beats, 0, 1'b0, '0);
        // abort in MULT
        do_start(4'd14, 16'($urandom), 12'($urandom));
        feed_beats(cur_beats, 0, 1'b0, '0);
        tick();
        // abort in ADD
        do_start(4'd6, 16'($urandom), 12'($urandom));
        feed_beats(cur_beats, 2, 1'b0, '0);
        finish_check();
        nvec++;
        if (done_cnt - d0 != 1) begin
            nerr++;
            $display("FAIL abort_pulses got=%0d required=1", done_cnt - d0);
        end
    endtask

    task automatic test_big();
        do_start(4'd15, 16'hFFFF, 12'hFFF);
        feed_beats(cur_beats, 0, 1'b1, {4{9'h100}});
        nvec++;
        if (cur_beats != 1024 || exp_acc != 64'd1044480) begin
            nerr++;
            $display("FAIL big_sad got=%0d beats=%0d required=1044480 beats=1024", exp_acc, cur_beats);
        end
        finish_check();
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        do_start(4'd4, 16'($urandom), 12'($urandom));
        feed_beats(cur_beats, 0, 1'b0, '0);
        #1;
        rst = 1'b1;
        #1;
        nvec++;
        if (rdcost !== 21'd0 || rdcost_done !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid rdcost=%0d done=%b busy=%b ready=%b, required 0 0 0 0",
                     rdcost, rdcost_done, busy, res_ready);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        nvec++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid_nodone pulses=%0d busy=%b, required 0 0", done_cnt - d0, busy);
        end
        do_start(4'd5, 16'($urandom), 12'($urandom));
        feed_beats(cur_beats, 2, 1'b0, '0);
        finish_check();
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [20:0] exp_a;
        d0 = done_cnt;
        do_start(4'd4, 16'($urandom), 12'($urandom));
        feed_beats(cur_beats, 0, 1'b0, '0);
        exp_a = model_cost();
        tick();
        tick();
        nvec++;
        if (rdcost_done !== 1'b1 || rdcost !== exp_a) begin
            nerr++;
            $display("FAIL b2b_first done=%b rdcost=%0d, required 1 %0d", rdcost_done, rdcost, exp_a);
        end
        do_start(4'd5, 16'($urandom), 12'($urandom));
        feed_beats(cur_beats, 0, 1'b0, '0);
        finish_check();
        nvec++;
        if (done_cnt - d0 != 2) begin
            nerr++;
            $display("FAIL b2b_pulses got=%0d required=2", done_cnt - d0);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        done_cnt = 0;
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_abort();
        test_big();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
